// File: rtl/instr_mem_sync.sv
// Byte-addressed instruction memory for the fetch stage.
// Synchronous one-cycle read behind a req/ready/valid handshake with
// consumer hold, plus a byte-serial loader with an auto-incrementing pointer.
//
// state | meaning
// IDLE  | fetches accepted, loader inactive
// LOAD  | loader owns the memory, fetches refused
module instr_mem_sync #(
  parameter int unsigned DEPTH_BYTES = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter bit          BIG_ENDIAN  = 1'b0,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic [1:0]        fetch_fault,
  input  logic              fetch_hold,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_we,
  input  logic [7:0]        load_data,
  input  logic              load_done,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count
);

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W+1)'(DEPTH_BYTES);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [1:0]        FAULT_OK  = 2'b00;
  localparam logic [1:0]        FAULT_MIS = 2'b01;
  localparam logic [1:0]        FAULT_OOR = 2'b10;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [1:0]        fault_q, fault_d;

  logic [7:0]        mem [DEPTH_BYTES];

  logic              hold_out;
  logic              accept;
  logic              mem_we;
  logic              misaligned;
  logic              out_of_range;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       word;

  // Address checks and word assembly; only the in-range low bits index the array
  always_comb begin
    misaligned   = (fetch_addr[1:0] != 2'b00);
    out_of_range = ((fetch_addr >> ADDR_W) != 32'd0);
    b0 = mem[{fetch_addr[ADDR_W-1:2], 2'b00}];
    b1 = mem[{fetch_addr[ADDR_W-1:2], 2'b01}];
    b2 = mem[{fetch_addr[ADDR_W-1:2], 2'b10}];
    b3 = mem[{fetch_addr[ADDR_W-1:2], 2'b11}];
    word = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  end

  assign hold_out    = valid_q && fetch_hold;
  assign fetch_ready = (state_q == IDLE) && !load_start && !hold_out;
  assign accept      = fetch_req && fetch_ready;

  // Fetch pipeline next state: freeze while held, otherwise capture accepted fetch
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (!hold_out) begin
      valid_d = accept;
      if (accept) begin
        if (misaligned) begin
          instr_d = NOP_WORD;
          fault_d = FAULT_MIS;
        end else if (out_of_range) begin
          instr_d = NOP_WORD;
          fault_d = FAULT_OOR;
        end else begin
          instr_d = word;
          fault_d = FAULT_OK;
        end
      end
    end
  end

  // Loader FSM next state: load_start always wins and reloads the pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    mem_we  = 1'b0;
    if (load_start) begin
      state_d = LOAD;
      ptr_d   = load_addr;
      count_d = '0;
    end else if (state_q == LOAD) begin
      if (load_we) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + PTR_ONE;
        if (count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;
      end
      if (load_done) state_d = IDLE;
    end
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
      fault_q <= FAULT_OK;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  // Memory array write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr_q] <= load_data;
  end

  assign fetch_valid = valid_q;
  assign fetch_instr = instr_q;
  assign fetch_fault = fault_q;
  assign load_busy   = (state_q == LOAD);
  assign load_count  = count_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Testbench for instr_mem_sync: little- and big-endian instances share stimulus.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'hDEAD_0013;

  logic        clk, rst;
  logic        fetch_req, fetch_hold;
  logic [31:0] fetch_addr;
  logic        load_start, load_we, load_done;
  logic [7:0]  load_addr, load_data;

  logic        rdy_l, val_l, busy_l;
  logic [31:0] instr_l;
  logic [1:0]  fault_l;
  logic [8:0]  cnt_l;
  logic        rdy_b, val_b, busy_b;
  logic [31:0] instr_b;
  logic [1:0]  fault_b;
  logic [8:0]  cnt_b;

  instr_mem_sync #(.DEPTH_BYTES(256), .ADDR_W(8), .BIG_ENDIAN(1'b0), .NOP_WORD(NOP)) dut_le (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(rdy_l), .fetch_valid(val_l), .fetch_instr(instr_l), .fetch_fault(fault_l),
    .fetch_hold(fetch_hold), .load_start(load_start), .load_addr(load_addr),
    .load_we(load_we), .load_data(load_data), .load_done(load_done),
    .load_busy(busy_l), .load_count(cnt_l));

  instr_mem_sync #(.DEPTH_BYTES(256), .ADDR_W(8), .BIG_ENDIAN(1'b1), .NOP_WORD(NOP)) dut_be (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(rdy_b), .fetch_valid(val_b), .fetch_instr(instr_b), .fetch_fault(fault_b),
    .fetch_hold(fetch_hold), .load_start(load_start), .load_addr(load_addr),
    .load_we(load_we), .load_data(load_data), .load_done(load_done),
    .load_busy(busy_b), .load_count(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: plain byte array, pointer and count
  logic [7:0] mm [256];
  int mptr = 0;
  int mcnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_le;
    logic [31:0] exp_be;
    logic [1:0]  exp_f;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] m_fault(input logic [31:0] a);
    if (a % 4 != 0) return 2'b01;
    if (a > 252) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_le(input logic [31:0] a);
    if (m_fault(a) != 2'b00) return NOP;
    return {mm[a+3], mm[a+2], mm[a+1], mm[a]};
  endfunction

  function automatic logic [31:0] m_be(input logic [31:0] a);
    if (m_fault(a) != 2'b00) return NOP;
    return {mm[a], mm[a+1], mm[a+2], mm[a+3]};
  endfunction

  task automatic load_begin(input logic [7:0] base);
    load_start = 1'b1;
    load_addr  = base;
    tick();
    load_start = 1'b0;
    mptr = int'(base);
    mcnt = 0;
    chk("load_busy_on_start", {31'd0, busy_l}, 32'd1);
    chk("load_count_on_start", {23'd0, cnt_l}, 32'd0);
  endtask

  task automatic load_byte(input logic [7:0] d);
    load_we   = 1'b1;
    load_data = d;
    tick();
    load_we = 1'b0;
    mm[mptr] = d;
    mptr = (mptr + 1) % 256;
    mcnt = (mcnt < 256) ? mcnt + 1 : 256;
    chk("load_count", {23'd0, cnt_l}, 32'(mcnt));
  endtask

  task automatic load_end();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("load_busy_after_done", {31'd0, busy_l}, 32'd0);
  endtask

  task automatic fetch_exp(input logic [31:0] a, input logic [31:0] e_le,
                           input logic [31:0] e_be, input logic [1:0] e_f);
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk("fetch_ready", {31'd0, rdy_l}, 32'd1);
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    chk("fetch_valid", {31'd0, val_l}, 32'd1);
    chk("fetch_instr_le", instr_l, e_le);
    chk("fetch_instr_be", instr_b, e_be);
    chk("fetch_fault", {30'd0, fault_l}, {30'd0, e_f});
  endtask

  task automatic fetch_model(input logic [31:0] a);
    fetch_exp(a, m_le(a), m_be(a), m_fault(a));
  endtask

  logic [31:0] a;
  logic [31:0] pre_le;

  initial begin
    rst = 1'b1;
    fetch_req = 1'b0; fetch_hold = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_we = 1'b0; load_done = 1'b0;
    load_addr = '0; load_data = '0;
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;

    #3;
    chk("rst_valid", {31'd0, val_l}, 32'd0);
    chk("rst_instr", instr_l, NOP);
    chk("rst_fault", {30'd0, fault_l}, 32'd0);
    chk("rst_busy", {31'd0, busy_l}, 32'd0);
    chk("rst_count", {23'd0, cnt_l}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("idle_ready", {31'd0, rdy_l}, 32'd1);

    // Program at 0 and at the top word
    load_begin(8'h00);
    load_byte(8'h00); load_byte(8'h00); load_byte(8'h08); load_byte(8'h8C);
    load_end();
    load_begin(8'hFC);
    load_byte(8'h11); load_byte(8'h22); load_byte(8'h33); load_byte(8'h44);
    load_end();

    tbl[0] = '{32'h0000_0000, 32'h8C08_0000, 32'h0000_088C, 2'b00};
    tbl[1] = '{32'h0000_0002, NOP,           NOP,           2'b01};
    tbl[2] = '{32'h0000_0100, NOP,           NOP,           2'b10};
    tbl[3] = '{32'h0000_0101, NOP,           NOP,           2'b01};
    tbl[4] = '{32'h0000_00FC, 32'h4433_2211, 32'h1122_3344, 2'b00};
    tbl[5] = '{32'hFFFF_FFFC, NOP,           NOP,           2'b10};
    tbl[6] = '{32'h0000_0200, NOP,           NOP,           2'b10};
    for (int i = 0; i < 7; i++) fetch_exp(tbl[i].addr, tbl[i].exp_le, tbl[i].exp_be, tbl[i].exp_f);
    tick();
    chk("valid_drops_idle", {31'd0, val_l}, 32'd0);
    chk("instr_kept_idle", instr_l, 32'h0000_0000 | NOP);

    // Pointer wrap, then saturation in the same load session
    load_begin(8'hFE);
    load_byte(8'hAA); load_byte(8'hBB); load_byte(8'hCC); load_byte(8'hDD);
    for (int i = 0; i < 300; i++) begin
      if (i == 0) begin
        load_done = 1'b0;
      end
      load_byte(8'($urandom));
    end
    chk("count_saturated", {23'd0, cnt_l}, 32'd256);
    load_we = 1'b1;
    tick();
    load_we = 1'b0;
    chk("load_we_ignored_after_done_prep", {23'd0, cnt_l}, 32'd256);
    mm[mptr] = load_data;
    mptr = (mptr + 1) % 256;
    load_end();
    load_we = 1'b1;
    load_data = 8'h5A;
    tick();
    load_we = 1'b0;
    chk("load_we_idle_ignored_count", {23'd0, cnt_l}, 32'd256);

    // Randomized fetches against the byte-array model
    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 263));
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) a = $urandom;
      fetch_model(a);
    end
    fetch_model(32'h0000_00FC);
    tick();

    // Hold with back-to-back fetches 0, 4, 8
    fetch_req = 1'b1; fetch_addr = 32'h0;
    tick();
    chk("hold_v0", {31'd0, val_l}, 32'd1);
    chk("hold_i0", instr_l, m_le(0));
    fetch_hold = 1'b1; fetch_addr = 32'h4;
    for (int k = 0; k < 2; k++) begin
      #1 chk("hold_ready_low", {31'd0, rdy_l}, 32'd0);
      tick();
      chk("hold_frozen_v", {31'd0, val_l}, 32'd1);
      chk("hold_frozen_i", instr_l, m_le(0));
    end
    fetch_hold = 1'b0;
    #1 chk("unhold_ready", {31'd0, rdy_l}, 32'd1);
    tick();
    chk("b2b_i4", instr_l, m_le(4));
    fetch_addr = 32'h8;
    tick();
    chk("b2b_i8", instr_l, m_le(8));
    chk("b2b_v8", {31'd0, val_l}, 32'd1);
    fetch_req = 1'b0;
    tick();
    chk("b2b_drop", {31'd0, val_l}, 32'd0);

    // Fetch and load_start collide in IDLE
    fetch_req = 1'b1; fetch_addr = 32'h10;
    load_start = 1'b1; load_addr = 8'h10;
    #1 chk("collide_ready", {31'd0, rdy_l}, 32'd0);
    tick();
    load_start = 1'b0; fetch_req = 1'b0;
    mptr = 16; mcnt = 0;
    chk("collide_no_valid", {31'd0, val_l}, 32'd0);
    chk("collide_busy", {31'd0, busy_l}, 32'd1);
    load_byte(8'h5A); load_byte(8'hA5); load_byte(8'h01); load_byte(8'h02);
    load_end();
    fetch_model(32'h10);
    chk("coherent_new", instr_l, 32'h0201_A55A);
    tick();

    // Held output across load_start, then reset mid-load
    fetch_req = 1'b1; fetch_addr = 32'h20;
    tick();
    pre_le = m_le(32'h20);
    fetch_req = 1'b0;
    fetch_hold = 1'b1;
    chk("pre_load_word", instr_l, pre_le);
    load_begin(8'h20);
    chk("held_through_start_v", {31'd0, val_l}, 32'd1);
    load_byte(8'h77); load_byte(8'h88);
    chk("held_through_load_i", instr_l, pre_le);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy_l}, 32'd0);
    chk("async_rst_valid", {31'd0, val_l}, 32'd0);
    chk("async_rst_count", {23'd0, cnt_l}, 32'd0);
    #2 rst = 1'b0;
    fetch_hold = 1'b0;
    tick();
    fetch_model(32'h20);
    chk("bytes_persist", {16'd0, instr_l[15:0]}, 32'h0000_8877);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
